fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the decoder. It owns the PC and issues in-order word requests to instruction memory over a valid/ready handshake. Returned words are buffered in a small in-order queue and presented to decode as an inst/pc pair with valid/ready. On a taken jump or branch redirect from execute, it flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 85 ++++++++
 rtl/fetch_unit_chk.sv | 22 ++
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
// Holds the default reset PC, the fault cause codes and the counter-width helper.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FAULT_NONE              = 2'd0,
    FAULT_MISALIGNED_TARGET = 2'd1
  } fault_cause_e;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic target_misaligned(input logic [1:0] low_bits);
    return (low_bits != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetch entries {pc, data, filled}.
// Entries are allocated at request time and filled in order as responses return.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alloc,
  input  logic [XLEN-1:0]  alloc_pc,
  input  logic             fill,
  input  logic [XLEN-1:0]  fill_data,
  input  logic             pop,
  input  logic             flush,
  output logic             head_filled,
  output logic [XLEN-1:0]  head_pc,
  output logic [XLEN-1:0]  head_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] unfilled
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  pc_r   [DEPTH];
  logic [XLEN-1:0]  data_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [PTR_W-1:0] head_r, tail_r, fill_ptr_r;
  logic [CNT_W-1:0] count_r, unfilled_r;
  logic             do_fill_s, do_pop_s;

  // A fill with nothing outstanding or a pop of an empty head is ignored.
  always_comb begin
    do_fill_s = fill && (unfilled_r != {CNT_W{1'b0}});
    do_pop_s  = pop && filled_r[head_r];
  end

  // Pointer, occupancy and entry storage update; flush empties everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_r[i]   <= {XLEN{1'b0}};
        data_r[i] <= {XLEN{1'b0}};
      end
      filled_r   <= {DEPTH{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      unfilled_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      filled_r   <= {DEPTH{1'b0}};
      head_r     <= {PTR_W{1'b0}};
      tail_r     <= {PTR_W{1'b0}};
      fill_ptr_r <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      unfilled_r <= {CNT_W{1'b0}};
    end else begin
      if (alloc) begin
        pc_r[tail_r] <= alloc_pc;
        tail_r       <= tail_r + PTR_W'(1);
      end
      if (do_fill_s) begin
        data_r[fill_ptr_r]   <= fill_data;
        filled_r[fill_ptr_r] <= 1'b1;
        fill_ptr_r           <= fill_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        filled_r[head_r] <= 1'b0;
        head_r           <= head_r + PTR_W'(1);
      end
      count_r    <= count_r + CNT_W'(alloc) - CNT_W'(do_pop_s);
      unfilled_r <= unfilled_r + CNT_W'(alloc) - CNT_W'(do_fill_s);
    end
  end

  assign head_filled = filled_r[head_r];
  assign head_pc     = pc_r[head_r];
  assign head_data   = data_r[head_r];
  assign count       = count_r;
  assign unfilled    = unfilled_r;

endmodule

// File: rtl/fetch_unit_chk.sv
// Protocol checks for the fetch stage: no orphan responses, queue never over-allocated.
module fetch_unit_chk
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input logic             clock,
  input logic             reset_n,
  input logic             resp_valid,
  input logic [CNT_W-1:0] drop_cnt,
  input logic [CNT_W-1:0] unfilled,
  input logic [CNT_W-1:0] count
);

  a_no_orphan_resp: assert property (@(posedge clock) disable iff (!reset_n)
    !(resp_valid && (drop_cnt == {CNT_W{1'b0}}) && (unfilled == {CNT_W{1'b0}})));

  a_count_bound: assert property (@(posedge clock) disable iff (!reset_n)
    (count <= CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests and
// feeds decode from an in-order queue, dropping stale responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault
);

  localparam int unsigned     CNT_W   = cnt_width(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);

  logic [XLEN-1:0]  pc_r;
  logic [CNT_W-1:0] drop_cnt_r;
  logic             fault_r;
  logic [CNT_W-1:0] q_count_s, q_unfilled_s, drop_next_s;
  logic             credit_s, req_fire_s, resp_drop_s, fill_s, pop_s;

  // Handshake qualification and stale-response accounting.
  always_comb begin
    credit_s       = (q_count_s < CNT_W'(DEPTH));
    imem_req_valid = reset_n && credit_s && !redirect && !fault_r;
    req_fire_s     = imem_req_valid && imem_req_ready;
    resp_drop_s    = imem_resp_valid && (drop_cnt_r != {CNT_W{1'b0}});
    fill_s         = imem_resp_valid && !resp_drop_s && !redirect;
    pop_s          = inst_valid && inst_ready && !redirect;
    // Any response in a redirect cycle is consumed here, so it comes off the total.
    if (redirect) begin
      drop_next_s = drop_cnt_r + q_unfilled_s - CNT_W'(imem_resp_valid);
    end else begin
      drop_next_s = drop_cnt_r - CNT_W'(resp_drop_s);
    end
  end

  // PC, drop counter and sticky misaligned-target fault.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_r       <= RESET_PC;
      drop_cnt_r <= {CNT_W{1'b0}};
      fault_r    <= 1'b0;
    end else begin
      drop_cnt_r <= drop_next_s;
      if (redirect) begin
        pc_r    <= redirect_pc;
        fault_r <= target_misaligned(redirect_pc[1:0]);
      end else if (req_fire_s) begin
        pc_r <= pc_r + PC_STEP;
      end
    end
  end

  assign imem_req_addr = pc_r;
  assign fetch_fault   = fault_r;

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock       (clock),
    .reset_n     (reset_n),
    .alloc       (req_fire_s),
    .alloc_pc    (pc_r),
    .fill        (fill_s),
    .fill_data   (imem_resp_data),
    .pop         (pop_s),
    .flush       (redirect),
    .head_filled (inst_valid),
    .head_pc     (inst_pc),
    .head_data   (inst),
    .count       (q_count_s),
    .unfilled    (q_unfilled_s)
  );

  fetch_unit_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clock      (clock),
    .reset_n    (reset_n),
    .resp_valid (imem_resp_valid),
    .drop_cnt   (drop_cnt_r),
    .unfilled   (q_unfilled_s),
    .count      (q_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory with variable latency and a
// queue-level model of which (pc, word) pairs decode must see, tagged by redirect epoch.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int lat_max = 0;

  // Memory: accepted requests in order, each tagged with its epoch and due cycle.
  logic [31:0] mem_addr[$];
  int          mem_epoch[$];
  int          mem_due[$];
  int          mem_last_due = -1;

  // Model: PCs allocated in the current stream and the words returned for them.
  logic [31:0] m_pc = 32'h0;
  bit          m_fault = 1'b0;
  logic [31:0] m_pcs[$];
  logic [31:0] m_data[$];
  int          epoch = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic reset_check();
    check_val("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check_val("rst_req_addr", imem_req_addr, 32'h0000_0000);
    check_val("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check_val("rst_inst", inst, 32'h0);
    check_val("rst_inst_pc", inst_pc, 32'h0);
    check_val("rst_fault", {31'b0, fetch_fault}, 32'h0);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_fault = 1'b0;
    m_pcs.delete();
    m_data.delete();
    mem_addr.delete();
    mem_epoch.delete();
    mem_due.delete();
    mem_last_due = cyc;
    epoch++;
  endtask

  // One clock cycle: entered at a falling edge, drives inputs, checks, updates model.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit rq_rdy, input bit in_rdy);
    bit          resp_now, stale, exp_rv, exp_iv, rd_eff;
    logic [31:0] resp_addr;
    int          due;
    resp_now = (mem_addr.size() > 0) && (mem_due[0] <= cyc);
    rd_eff = rd && ((mem_addr.size() - int'(resp_now)) <= DEPTH);
    redirect = rd_eff;
    redirect_pc = rpc;
    imem_req_ready = rq_rdy;
    inst_ready = in_rdy;
    imem_resp_valid = resp_now;
    imem_resp_data = resp_now ? mem_word(mem_addr[0]) : $urandom;
    #1;
    exp_rv = (m_pcs.size() < DEPTH) && !rd_eff && !m_fault;
    exp_iv = (m_data.size() > 0);
    check_val("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    check_val("req_addr", imem_req_addr, m_pc);
    check_val("inst_valid", {31'b0, inst_valid}, {31'b0, exp_iv});
    check_val("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    if (exp_iv) begin
      check_val("inst_pc", inst_pc, m_pcs[0]);
      check_val("inst", inst, m_data[0]);
    end
    stale = 1'b0;
    resp_addr = 32'h0;
    if (resp_now) begin
      stale = (mem_epoch[0] != epoch);
      resp_addr = mem_addr[0];
      void'(mem_addr.pop_front());
      void'(mem_epoch.pop_front());
      void'(mem_due.pop_front());
    end
    if (rd_eff) begin
      m_pcs.delete();
      m_data.delete();
      epoch++;
      m_pc = rpc;
      m_fault = (rpc[1:0] != 2'b00);
    end else begin
      if (exp_iv && in_rdy) begin
        void'(m_pcs.pop_front());
        void'(m_data.pop_front());
      end
      if (resp_now && !stale) m_data.push_back(mem_word(resp_addr));
      if (exp_rv && rq_rdy) begin
        due = cyc + 1 + $urandom_range(0, lat_max);
        if (due <= mem_last_due) due = mem_last_due + 1;
        mem_last_due = due;
        m_pcs.push_back(m_pc);
        mem_addr.push_back(m_pc);
        mem_epoch.push_back(epoch);
        mem_due.push_back(due);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  initial begin
    logic [31:0] r, rpc;
    #2;
    reset_check();
    @(negedge clock);
    reset_n = 1'b1;
    // Streaming with a one-cycle memory.
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Decoder backpressure, then release.
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Memory not ready for three cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Redirect with two requests still outstanding in a slow memory.
    lat_max = 4;
    for (int i = 0; i < 2; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
    lat_max = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Redirect in the same cycle as a response and a pop.
    step(1'b1, 32'h0000_0180, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Misaligned target halts fetch; an aligned one resumes it.
    step(1'b1, 32'h0000_0102, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // PC wrap at the top of the address space.
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) lat_max = $urandom_range(0, 3);
      r = $urandom;
      case ($urandom_range(0, 7))
        0:       rpc = r;
        1:       rpc = 32'hFFFF_FFF8;
        default: rpc = {r[31:2], 2'b00};
      endcase
      step($urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    // Asynchronous reset in the middle of a cycle.
    #3;
    reset_n = 1'b0;
    #1;
    reset_check();
    model_reset();
    redirect = 1'b0;
    imem_resp_valid = 1'b0;
    @(negedge clock);
    cyc++;
    reset_n = 1'b1;
    lat_max = 1;
    for (int i = 0; i < 30; i++) step(1'b0, 32'h0, $urandom_range(0, 3) != 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
